// File: rtl/sr_window_gen.sv
// sr_window_gen
//   Streaming 3x3 neighbourhood generator. Accepts one raster-ordered frame
//   of pixels and emits one zero-padded 3x3 window per pixel, in raster
//   order, with the centre coordinates attached.
//
// Ports
//   clk_r        clock (all logic on rising edge)
//   rst_n        asynchronous active-low reset
//   frame_start  one-cycle pulse; arms or restarts capture of a frame
//   in_valid     in_pixel valid          in_ready   pixel accepted this cycle
//   in_pixel     raster pixel, (0,0) first
//   win_valid    window outputs valid    win_ready  consumer takes window
//   win_data     9 slots, slot k = [k*PIXEL_WIDTH +: PIXEL_WIDTH], row-major
//   win_x/win_y  centre coordinates      win_last   window (WIDTH-1,HEIGHT-1)
//   frame_done   one-cycle pulse after the last window handshake
module sr_window_gen #(
    parameter int unsigned WIDTH       = 320,
    parameter int unsigned HEIGHT      = 240,
    parameter int unsigned PIXEL_WIDTH = 24
) (
    input  logic                        clk_r,
    input  logic                        rst_n,
    input  logic                        frame_start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PIXEL_WIDTH-1:0]      in_pixel,
    output logic                        win_valid,
    input  logic                        win_ready,
    output logic [9*PIXEL_WIDTH-1:0]    win_data,
    output logic [$clog2(WIDTH)-1:0]    win_x,
    output logic [$clog2(HEIGHT)-1:0]   win_y,
    output logic                        win_last,
    output logic                        frame_done
);

    localparam int unsigned N  = WIDTH * HEIGHT;
    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned YW = $clog2(HEIGHT);
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
    // One image column of three vertically adjacent pixels: [0]=top, [2]=bottom
    typedef logic [2:0][PIXEL_WIDTH-1:0] col_t;

    state_t state_q, state_d;

    logic [CW-1:0]           acc, emit;
    logic [XW-1:0]           sx, sx_next, raddr, cx;
    logic [YW:0]             sy, cy;
    col_t                    c1, c2, cn, col_l, col_r;
    logic [8:0][PIXEL_WIDTH-1:0] win_d;
    logic [PIXEL_WIDTH-1:0]  lb0_mem [WIDTH];
    logic [PIXEL_WIDTH-1:0]  lb1_mem [WIDTH];
    logic [PIXEL_WIDTH-1:0]  lb0_rd, lb1_rd;
    logic                    in_xfer, out_xfer, flushing, step, emit_now;

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            FILL:    in_ready = 1'b1;
            RUN:     in_ready = ((acc - emit) < CW'(WIDTH + 2)) && (acc < CW'(N));
            default: in_ready = 1'b0;
        endcase
        if (frame_start) in_ready = 1'b0;
    end

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = win_valid && win_ready && !frame_start;
    assign flushing = (state_q == FLUSH);

    // (sx,sy) walks the pixel raster one column per step. Real steps consume
    // an input pixel; once the frame is in, each output handshake drives a
    // virtual step over rows HEIGHT and HEIGHT+1 with a zero bottom pixel,
    // which produces the remaining bottom-padded windows.
    assign step = in_xfer || (flushing && out_xfer && !win_last);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = state_q;
            FILL:    if (in_xfer && acc == CW'(WIDTH + 1)) state_d = RUN;
            RUN:     if (in_xfer && acc == CW'(N - 1)) state_d = FLUSH;
            FLUSH:   if (out_xfer && win_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (frame_start) state_d = FILL;
    end

    always_comb begin
        sx_next = (sx == XW'(WIDTH - 1)) ? '0 : sx + 1'b1;
        // RAM address runs one step ahead so the 1-cycle read is ready in time
        raddr   = frame_start ? '0 : (step ? sx_next : sx);

        cn[0] = (sy >= (YW+1)'(2)) ? lb0_rd : '0;
        cn[1] = (sy != '0) ? lb1_rd : '0;
        cn[2] = flushing ? '0 : in_pixel;

        // Column x completes window (x-1, y-1); column 0 instead closes the
        // previous line's last window, with a zero right-hand column.
        col_l = (sx == XW'(1)) ? '0 : c2;
        col_r = (sx == '0) ? '0 : cn;
        for (int unsigned r = 0; r < 3; r++) begin
            win_d[r*3]     = col_l[r];
            win_d[r*3 + 1] = c1[r];
            win_d[r*3 + 2] = col_r[r];
        end

        if (sx == '0) begin
            cx = XW'(WIDTH - 1);
            cy = sy - (YW+1)'(2);
        end else begin
            cx = sx - 1'b1;
            cy = sy - 1'b1;
        end
        emit_now = (sy > (YW+1)'(1)) || ((sy == (YW+1)'(1)) && (sx != '0));
    end

    always_ff @(posedge clk_r or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_r or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            emit       <= '0;
            sx         <= '0;
            sy         <= '0;
            c1         <= '0;
            c2         <= '0;
            win_valid  <= 1'b0;
            win_data   <= '0;
            win_x      <= '0;
            win_y      <= '0;
            win_last   <= 1'b0;
            frame_done <= 1'b0;
        end else if (frame_start) begin
            acc        <= '0;
            emit       <= '0;
            sx         <= '0;
            sy         <= '0;
            win_valid  <= 1'b0;
            win_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= flushing && out_xfer && win_last;
            if (in_xfer) acc <= acc + 1'b1;
            if (out_xfer) begin
                emit      <= emit + 1'b1;
                win_valid <= 1'b0;
                win_last  <= 1'b0;
            end
            if (step) begin
                c2 <= c1;
                c1 <= cn;
                sx <= sx_next;
                if (sx == XW'(WIDTH - 1)) sy <= sy + 1'b1;
                if (emit_now) begin
                    win_valid <= 1'b1;
                    win_data  <= win_d;
                    win_x     <= cx;
                    win_y     <= cy[YW-1:0];
                    win_last  <= (cx == XW'(WIDTH - 1)) && (cy == (YW+1)'(HEIGHT - 1));
                end
            end
        end
    end

    // Line buffers: lb1 holds the previous row, lb0 the row before it
    always_ff @(posedge clk_r) begin
        if (in_xfer) begin
            lb0_mem[sx] <= lb1_rd;
            lb1_mem[sx] <= in_pixel;
        end
        lb0_rd <= lb0_mem[raddr];
        lb1_rd <= lb1_mem[raddr];
    end

endmodule

// File: tb/tb_sr_window_gen.sv
module tb_sr_window_gen;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int PW = 24;

    logic            clk_r = 1'b0;
    logic            rst_n = 1'b0;
    logic            frame_start = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [PW-1:0]   in_pixel = '0;
    logic            win_valid;
    logic            win_ready = 1'b1;
    logic [9*PW-1:0] win_data;
    logic [1:0]      win_x;
    logic [1:0]      win_y;
    logic            win_last;
    logic            frame_done;

    sr_window_gen #(.WIDTH(W), .HEIGHT(H), .PIXEL_WIDTH(PW)) dut (
        .clk_r(clk_r), .rst_n(rst_n), .frame_start(frame_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .win_x(win_x), .win_y(win_y), .win_last(win_last), .frame_done(frame_done)
    );

    always #5 clk_r = ~clk_r;

    int checks = 0;
    int errors = 0;
    int tick = 0;
    int acc_seen = 0;
    int acc6_tick = -1;
    int first_valid_tick = -1;
    int done_cnt = 0;
    logic [220:0] wq[$];
    logic [215:0] held1;

    always @(posedge clk_r) tick++;

    always @(negedge clk_r) begin
        if (rst_n) begin
            if (win_valid && first_valid_tick < 0) first_valid_tick = tick;
            if (win_valid && win_ready && !frame_start)
                wq.push_back({win_data, win_x, win_y, win_last});
            if (in_valid && in_ready) begin
                acc_seen++;
                if (acc_seen == 6) acc6_tick = tick;
            end
            if (frame_done) done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [215:0] mk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        int a[9];
        logic [215:0] r;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        r = '0;
        for (int k = 0; k < 9; k++) r[k*PW +: PW] = PW'(a[k]);
        return r;
    endfunction

    function automatic logic [215:0] model(input int x, input int y, input int base);
        logic [215:0] r;
        int px, py, k;
        r = '0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
                px = x + dx;
                py = y + dy;
                k  = (dy + 1) * 3 + dx + 1;
                if (px >= 0 && px < W && py >= 0 && py < H)
                    r[k*PW +: PW] = PW'(base + py * W + px + 1);
            end
        return r;
    endfunction

    function automatic logic [220:0] entry(input logic [215:0] d, input int x, input int y, input bit last);
        return {d, 2'(x), 2'(y), last};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick_in();
        @(posedge clk_r);
        #1;
    endtask

    task automatic start_frame();
        tick_in();
        wq.delete();
        done_cnt = 0;
        acc_seen = 0;
        acc6_tick = -1;
        first_valid_tick = -1;
        frame_start = 1'b1;
        tick_in();
        frame_start = 1'b0;
    endtask

    task automatic feed(input int base, input int n, input bit toggle);
        int i = 0;
        int cyc = 0;
        bit ph = 1'b1;
        while (i < n && cyc < 400) begin
            in_valid = toggle ? ph : 1'b1;
            in_pixel = PW'(base + i + 1);
            @(negedge clk_r);
            if (in_valid && in_ready) i++;
            @(posedge clk_r);
            #1;
            ph = !ph;
            cyc++;
        end
        in_valid = 1'b0;
        chk("feed_count", i, n);
    endtask

    task automatic wait_done();
        int c = 0;
        while (done_cnt == 0 && c < 200) begin
            @(negedge clk_r);
            c++;
        end
        repeat (5) @(negedge clk_r);
        tick_in();
    endtask

    task automatic check_frame(input int base, input string tag);
        chk({tag, "_count"}, wq.size(), 12);
        for (int i = 0; i < 12; i++)
            if (i < wq.size())
                chk($sformatf("%s_w%0d", tag, i), wq[i],
                    entry(model(i % W, i / W, base), i % W, i / W, i == 11));
        chk({tag, "_done"}, done_cnt, 1);
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk_r);
        #1;
        chk("rst_valid", win_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_data", win_data, 0);
        chk("rst_xyl", {win_x, win_y, win_last}, 0);
        rst_n = 1'b1;
        tick_in();

        // 1: back-to-back frame
        start_frame();
        feed(0, 12, 1'b0);
        wait_done();
        chk("t1_first_valid", first_valid_tick, acc6_tick + 1);
        if (wq.size() > 0) chk("t1_win00", wq[0][220:5], mk(0, 0, 0, 0, 1, 2, 0, 5, 6));
        check_frame(0, "t1");
        chk("t1_idle_ready", in_ready, 0);

        // 2: last window and an interior window
        if (wq.size() == 12) begin
            chk("t2_last", wq[11], entry(mk(7, 8, 0, 11, 12, 0, 0, 0, 0), 3, 2, 1'b1));
            chk("t2_w11", wq[5], entry(mk(1, 2, 3, 5, 6, 7, 9, 10, 11), 1, 1, 1'b0));
        end

        // 3: consumer stall
        start_frame();
        fork
            feed(0, 12, 1'b0);
            begin
                win_ready = 1'b0;
                repeat (10) tick_in();
                held1 = win_data;
                repeat (10) tick_in();
                chk("t3_acc_stalled", acc_seen, 6);
                chk("t3_in_ready", in_ready, 0);
                chk("t3_valid", win_valid, 1);
                chk("t3_held_early", held1, mk(0, 0, 0, 0, 1, 2, 0, 5, 6));
                chk("t3_held_late", win_data, mk(0, 0, 0, 0, 1, 2, 0, 5, 6));
                chk("t3_xy", {win_x, win_y, win_last}, 0);
                win_ready = 1'b1;
            end
        join
        wait_done();
        check_frame(0, "t3");

        // 4: in_valid toggling
        start_frame();
        feed(0, 12, 1'b1);
        wait_done();
        check_frame(0, "t4");

        // 5: abort after 7 pixels, then a new frame with offset values
        start_frame();
        feed(0, 7, 1'b0);
        start_frame();
        chk("t5_abort_valid", win_valid, 0);
        feed(100, 12, 1'b0);
        wait_done();
        if (wq.size() > 0) chk("t5_win00", wq[0][220:5], mk(0, 0, 0, 0, 101, 102, 0, 105, 106));
        check_frame(100, "t5");

        // 6: reset mid-FLUSH, then a clean frame
        start_frame();
        feed(0, 12, 1'b0);
        win_ready = 1'b0;
        tick_in();
        tick_in();
        chk("t6_pre_valid", win_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", win_valid, 0);
        chk("t6_rst_in_ready", in_ready, 0);
        chk("t6_rst_done", frame_done, 0);
        chk("t6_rst_data", win_data, 0);
        chk("t6_rst_xyl", {win_x, win_y, win_last}, 0);
        tick_in();
        rst_n = 1'b1;
        win_ready = 1'b1;
        tick_in();
        start_frame();
        feed(0, 12, 1'b0);
        wait_done();
        chk("t6_first_valid", first_valid_tick, acc6_tick + 1);
        check_frame(0, "t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
